// File: rtl/vermibus_pkg.sv
// Shared definitions for the Vermibus two-master arbiter.
//   ADDR_W / DATA_W / STRB_W : bus field widths
//   arb_state_t              : arbiter grant state
//   vb_req_t                 : one master's request fields, bundled for muxing
//   grant_state()            : maps a master index onto its grant state
package vermibus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [STRB_W-1:0] wstrobe;
    logic [DATA_W-1:0] wdata;
  } vb_req_t;

  function automatic arb_state_t grant_state(input logic idx);
    return idx ? GRANT1 : GRANT0;
  endfunction

endpackage

// File: rtl/vermibus_watchdog.sv
// Slave-timeout watchdog for the Vermibus arbiter.
// Counts granted cycles in which the slave has not answered and flags the
// last cycle before a forced completion.
//   clk      : clock, rising edge
//   reset    : asynchronous, active-low reset
//   clear    : return the count to zero (has priority over count_en)
//   count_en : one more unanswered granted cycle
//   expired  : count has reached TIMEOUT_CYCLES-1; tied low when TIMEOUT_CYCLES==0
module vermibus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk, reset, clear, count_en};
    assign expired = 1'b0;
  end else begin : g_on
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturates rather than wrapping, so a missed clear can never fake a
    // fresh count.
    always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
        cnt_d = '0;
      end else if (count_en && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of block ordering in simulation.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign expired = (cnt_q == CNT_LAST);
  end

endmodule

// File: rtl/vermibus_arbiter.sv
// Two-master round-robin arbiter in front of the Vermibus device-decode fabric.
// Master 0 is the CPU, master 1 a DMA/debug agent. A grant is registered one
// cycle after the request and held for the whole valid..ready transaction.
// An optional watchdog forces an error completion when the slave stalls.
//   clk, reset           : clock; asynchronous active-low reset
//   mX_valid/address/
//   mX_wstrobe/wdata     : master X request (wstrobe 0 = read)
//   mX_rdata, mX_ready   : master X response, ready is a one-cycle pulse
//   s_valid/address/
//   s_wstrobe/wdata      : request forwarded to the slave fabric
//   s_rdata, s_ready     : slave response
//   timeout              : one-cycle pulse on a watchdog-forced completion
module vermibus_arbiter
  import vermibus_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = 64,
  parameter logic [DATA_W-1:0] ERROR_DATA     = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [STRB_W-1:0] m0_wstrobe,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ready,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [STRB_W-1:0] m1_wstrobe,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ready,
  output logic              s_valid,
  output logic [ADDR_W-1:0] s_address,
  output logic [STRB_W-1:0] s_wstrobe,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_ready,
  output logic              timeout
);

  arb_state_t  state_q, state_d;
  logic        last_q, last_d;    // master that completed most recently

  vb_req_t     m0_req, m1_req, sel_req;
  logic        granted, gnt_idx;
  logic        sel_valid, other_valid;
  logic        to_fire, done;
  logic [DATA_W-1:0] rsp_rdata;
  logic        wd_clear, wd_count, wd_expired;

  assign m0_req = '{address: m0_address, wstrobe: m0_wstrobe, wdata: m0_wdata};
  assign m1_req = '{address: m1_address, wstrobe: m1_wstrobe, wdata: m1_wdata};

  assign granted     = (state_q != IDLE);
  assign gnt_idx     = (state_q == GRANT1);
  assign sel_valid   = gnt_idx ? m1_valid : m0_valid;
  assign other_valid = gnt_idx ? m0_valid : m1_valid;
  assign sel_req     = gnt_idx ? m1_req : m0_req;

  // A real s_ready always beats the watchdog in the same cycle.
  assign to_fire   = granted & sel_valid & wd_expired & ~s_ready;
  assign done      = granted & sel_valid & (s_ready | to_fire);
  assign rsp_rdata = to_fire ? ERROR_DATA : s_rdata;
  assign timeout   = to_fire;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    s_valid   = 1'b0;
    s_address = '0;
    s_wstrobe = '0;
    s_wdata   = '0;
    m0_ready  = 1'b0;
    m0_rdata  = '0;
    m1_ready  = 1'b0;
    m1_rdata  = '0;
    wd_clear  = 1'b1;
    wd_count  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // With both requesting, the master that did not finish last wins.
        if (m0_valid && (!m1_valid || last_q)) begin
          state_d = GRANT0;
        end else if (m1_valid) begin
          state_d = GRANT1;
        end
      end

      GRANT0, GRANT1: begin
        s_valid   = sel_valid & ~to_fire;
        s_address = sel_req.address;
        s_wstrobe = sel_req.wstrobe;
        s_wdata   = sel_req.wdata;
        if (gnt_idx) begin
          m1_ready = done;
          m1_rdata = rsp_rdata;
        end else begin
          m0_ready = done;
          m0_rdata = rsp_rdata;
        end

        if (!sel_valid) begin
          // Master abandoned its request: release the bus without a ready.
          state_d = IDLE;
          last_d  = gnt_idx;
        end else if (done) begin
          last_d  = gnt_idx;
          state_d = other_valid ? grant_state(~gnt_idx) : IDLE;
        end else begin
          wd_clear = 1'b0;
          wd_count = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  vermibus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .count_en(wd_count),
    .expired (wd_expired)
  );

endmodule

// File: tb/tb_vermibus_arbiter.sv
// Self-checking bench for vermibus_arbiter: directed scenarios with literal
// expectations, then randomized masters and slave against a transaction-level
// model that is compared with the DUT on every falling clock edge.
module tb_vermibus_arbiter;

  localparam int unsigned TO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_valid, m1_valid, s_ready;
  logic [31:0] m0_address, m0_wdata, m1_address, m1_wdata, s_rdata;
  logic [3:0]  m0_wstrobe, m1_wstrobe;
  logic [31:0] m0_rdata, m1_rdata, s_address, s_wdata;
  logic        m0_ready, m1_ready, s_valid, timeout;
  logic [3:0]  s_wstrobe;

  always #5 clk = ~clk;

  vermibus_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .ERROR_DATA    (ERR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_valid  (m0_valid),
    .m0_address(m0_address),
    .m0_wstrobe(m0_wstrobe),
    .m0_wdata  (m0_wdata),
    .m0_rdata  (m0_rdata),
    .m0_ready  (m0_ready),
    .m1_valid  (m1_valid),
    .m1_address(m1_address),
    .m1_wstrobe(m1_wstrobe),
    .m1_wdata  (m1_wdata),
    .m1_rdata  (m1_rdata),
    .m1_ready  (m1_ready),
    .s_valid   (s_valid),
    .s_address (s_address),
    .s_wstrobe (s_wstrobe),
    .s_wdata   (s_wdata),
    .s_rdata   (s_rdata),
    .s_ready   (s_ready),
    .timeout   (timeout)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_to     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- transaction-level reference model ----------------
  // owner: -1 = bus free, else the master holding the grant.
  // age:   granted cycles so far without a slave answer.
  int owner = -1, last = 1, age = 0;
  int n_owner = -1, n_last = 1, n_age = 0;
  logic        e_sv, e_to, gv, ov, rdy, expire;
  logic [31:0] e_sa, e_sd, e_rd0, e_rd1, rd;
  logic [3:0]  e_ss;
  logic [1:0]  e_r;

  always @(negedge clk) begin
    e_sv = 0; e_sa = 0; e_ss = 0; e_sd = 0; e_r = 0; e_rd0 = 0; e_rd1 = 0; e_to = 0;
    if (!reset) begin
      n_owner = -1; n_last = 1; n_age = 0;
    end else if (owner < 0) begin
      n_last = last; n_age = 0;
      if (m0_valid && m1_valid) n_owner = 1 - last;
      else if (m0_valid)        n_owner = 0;
      else if (m1_valid)        n_owner = 1;
      else                      n_owner = -1;
    end else begin
      gv     = (owner == 0) ? m0_valid : m1_valid;
      ov     = (owner == 0) ? m1_valid : m0_valid;
      expire = (TO > 0) && gv && !s_ready && (age == int'(TO) - 1);
      rdy    = gv && (s_ready || expire);
      rd     = expire ? ERR : s_rdata;
      e_sv   = gv && !expire;
      e_sa   = (owner == 0) ? m0_address : m1_address;
      e_ss   = (owner == 0) ? m0_wstrobe : m1_wstrobe;
      e_sd   = (owner == 0) ? m0_wdata   : m1_wdata;
      if (owner == 0) begin e_r[0] = rdy; e_rd0 = rd; end
      else            begin e_r[1] = rdy; e_rd1 = rd; end
      e_to   = expire;
      if (expire) n_to++;
      n_owner = owner; n_last = last; n_age = age + 1;
      if (!gv) begin
        n_owner = -1; n_last = owner; n_age = 0;
      end else if (rdy) begin
        n_last = owner; n_owner = ov ? 1 - owner : -1; n_age = 0;
      end
    end
    check("model s_valid",   32'(s_valid),   32'(e_sv));
    check("model s_address", s_address,      e_sa);
    check("model s_wstrobe", 32'(s_wstrobe), 32'(e_ss));
    check("model s_wdata",   s_wdata,        e_sd);
    check("model m0_ready",  32'(m0_ready),  32'(e_r[0]));
    check("model m1_ready",  32'(m1_ready),  32'(e_r[1]));
    check("model m0_rdata",  m0_rdata,       e_rd0);
    check("model m1_rdata",  m1_rdata,       e_rd1);
    check("model timeout",   32'(timeout),   32'(e_to));
  end

  always @(posedge clk) begin
    if (!reset) begin
      owner <= -1; last <= 1; age <= 0;
    end else begin
      owner <= n_owner; last <= n_last; age <= n_age;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic new_req(input int x);
    if (x == 0) begin
      m0_valid = 1; m0_address = $urandom; m0_wstrobe = 4'($urandom_range(0, 15)); m0_wdata = $urandom;
    end else begin
      m1_valid = 1; m1_address = $urandom; m1_wstrobe = 4'($urandom_range(0, 15)); m1_wdata = $urandom;
    end
  endtask

  task automatic drop(input int x);
    if (x == 0) m0_valid = 0;
    else        m1_valid = 0;
  endtask

  logic [1:0] seen;
  logic       vx;
  int         to_base;

  initial begin
    m0_valid = 0; m0_address = 0; m0_wstrobe = 0; m0_wdata = 0;
    m1_valid = 0; m1_address = 0; m1_wstrobe = 0; m1_wdata = 0;
    s_ready = 0; s_rdata = 0;

    repeat (3) @(posedge clk);
    #1;
    check("reset s_valid",  32'(s_valid),  0);
    check("reset m0_ready", 32'(m0_ready), 0);
    check("reset timeout",  32'(timeout),  0);
    reset = 1;

    // 1: m0 read, slave answers on the second granted cycle
    m0_valid = 1; m0_address = 32'h0000_0010; m0_wstrobe = 0;
    #1 check("t1 idle s_valid", 32'(s_valid), 0);
    tick();
    check("t1 s_valid",   32'(s_valid), 1);
    check("t1 s_address", s_address,    32'h0000_0010);
    check("t1 m0_ready early", 32'(m0_ready), 0);
    tick();
    s_ready = 1; s_rdata = 32'h1234_5678;
    #1;
    check("t1 m0_ready", 32'(m0_ready), 1);
    check("t1 m0_rdata", m0_rdata,      32'h1234_5678);
    check("t1 m1_ready", 32'(m1_ready), 0);
    check("t1 m1_rdata", m1_rdata,      0);
    tick();
    m0_valid = 0; s_ready = 0; s_rdata = 0;
    #1 check("t1 back idle", 32'(s_valid), 0);

    // 3: m1 write forwarded unchanged
    m1_valid = 1; m1_address = 32'h8100_0000; m1_wstrobe = 4'b0001; m1_wdata = 32'h41;
    tick();
    check("t3 s_valid",   32'(s_valid),   1);
    check("t3 s_address", s_address,      32'h8100_0000);
    check("t3 s_wstrobe", 32'(s_wstrobe), 32'h1);
    check("t3 s_wdata",   s_wdata,        32'h41);
    s_ready = 1;
    #1;
    check("t3 m1_ready", 32'(m1_ready), 1);
    check("t3 m0_ready", 32'(m0_ready), 0);
    tick();
    m1_valid = 0; s_ready = 0;
    #1 check("t3 back idle", 32'(s_valid), 0);

    // 2: simultaneous requests, single-cycle slave; last finisher was m1
    m0_valid = 1; m0_address = 32'h100; m0_wstrobe = 0;
    m1_valid = 1; m1_address = 32'h200; m1_wstrobe = 0;
    s_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) m0_valid = 0;
      #1;
      check("t2 m0_ready",  32'(m0_ready), (i % 2 == 0) ? 1 : 0);
      check("t2 m1_ready",  32'(m1_ready), (i % 2 == 1) ? 1 : 0);
      check("t2 s_address", s_address,     (i % 2 == 0) ? 32'h100 : 32'h200);
    end
    tick();
    m1_valid = 0; s_ready = 0;
    #1 check("t2 back idle", 32'(s_valid), 0);

    // 4: slave silent to m0, m1 waiting
    m0_valid = 1; m0_address = 32'h300;
    m1_valid = 1; m1_address = 32'h400;
    s_rdata = 32'h5555_0000;
    tick();
    for (int c = 1; c < int'(TO); c++) begin
      check("t4 wait m0_ready", 32'(m0_ready), 0);
      check("t4 wait timeout",  32'(timeout),  0);
      tick();
    end
    check("t4 m0_ready", 32'(m0_ready), 1);
    check("t4 m0_rdata", m0_rdata,      ERR);
    check("t4 timeout",  32'(timeout),  1);
    check("t4 s_valid",  32'(s_valid),  0);
    tick();
    m0_valid = 0;
    #1;
    check("t4 m1 granted",  32'(s_valid), 1);
    check("t4 m1 address",  s_address,    32'h400);

    // 5: slave answers m1 exactly in the expiry cycle
    for (int c = 1; c < int'(TO); c++) tick();
    s_ready = 1; s_rdata = 32'hCAFE_0005;
    #1;
    check("t5 m1_ready", 32'(m1_ready), 1);
    check("t5 m1_rdata", m1_rdata,      32'hCAFE_0005);
    check("t5 timeout",  32'(timeout),  0);
    tick();
    m1_valid = 0;
    #1;
    check("t5 late ready m0", 32'(m0_ready), 0);
    check("t5 late ready m1", 32'(m1_ready), 0);
    s_ready = 0;

    // m0 finishes last so that, without a reset, m1 would win next
    m0_valid = 1; m0_address = 32'h500;
    tick();
    s_ready = 1;
    #1 check("t6 prep m0_ready", 32'(m0_ready), 1);
    tick();
    m0_valid = 0; s_ready = 0;

    // 6: reset while m1 owns the bus
    m1_valid = 1; m1_address = 32'h600;
    tick();
    check("t6 m1 granted", 32'(s_valid), 1);
    s_ready = 1;
    reset = 0;
    #1;
    check("t6 rst s_valid",   32'(s_valid),  0);
    check("t6 rst s_address", s_address,     0);
    check("t6 rst m1_ready",  32'(m1_ready), 0);
    check("t6 rst m1_rdata",  m1_rdata,      0);
    m0_valid = 1;
    tick();
    reset = 1;
    tick();
    check("t6 m0 first",  s_address,     32'h500);
    check("t6 m0_ready",  32'(m0_ready), 1);
    check("t6 m1 waits",  32'(m1_ready), 0);
    tick();
    m0_valid = 0;
    tick();
    m1_valid = 0; s_ready = 0;

    // randomized traffic, alternating responsive and stalled slave phases
    to_base = n_to;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      seen = {m1_ready, m0_ready};
      @(posedge clk);
      #1;
      for (int x = 0; x < 2; x++) begin
        vx = (x == 0) ? m0_valid : m1_valid;
        if (vx && seen[x]) begin
          if ($urandom_range(0, 1) == 0) new_req(x);
          else drop(x);
        end else if (vx && $urandom_range(0, 99) == 0) begin
          drop(x);
        end else if (!vx && $urandom_range(0, 2) == 0) begin
          new_req(x);
        end
      end
      if ((cyc / 200) % 2 == 1) s_ready = ($urandom_range(0, 39) == 0);
      else                      s_ready = ($urandom_range(0, 2) == 0);
      s_rdata = $urandom;
    end
    @(negedge clk);
    check("random timeouts seen", 32'(n_to > to_base), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
